shift_deserializer_16bit: RTL and testbench

//   Receive end of the left-shift serial link: accepts one bit per cycle, MSB first, and rebuilds a WIDTH-bit word.

---
 rtl/shift_deserializer_16bit_pkg.sv | 13 +
 rtl/shift_deserializer_16bit_if.sv | 40 ++++
 rtl/shift_deserializer_16bit_bit_counter.sv | 43 ++++
 rtl/shift_deserializer_16bit.sv | 102 ++++++++++
 tb/tb_shift_deserializer_16bit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_deserializer_16bit_pkg.sv
// Shared types and constants for the serial-link deserializer.
// FSM encoding and default word width.
package shift_deserializer_16bit_pkg;

  localparam int DESER_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/shift_deserializer_16bit_if.sv
// Serial-in / word-out bundle of the deserializer.
// master = link driver and consumer, slave = deserializer.
interface shift_deserializer_16bit_if
  import shift_deserializer_16bit_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH
) ();

  logic             start;
  logic             bit_valid;
  logic             bit_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             overrun;

  modport master (
    output start,
    output bit_valid,
    output bit_in,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  busy,
    input  overrun
  );

  modport slave (
    input  start,
    input  bit_valid,
    input  bit_in,
    input  data_ready,
    output data_out,
    output data_valid,
    output busy,
    output overrun
  );

endinterface

// File: rtl/shift_deserializer_16bit_bit_counter.sv
// Counts accepted serial bits; flags the last bit of a word.
// Clear has priority over increment.
module shift_deserializer_16bit_bit_counter
  import shift_deserializer_16bit_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear, step or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == LAST);

endmodule

// File: rtl/shift_deserializer_16bit.sv
// MSB-first serial receiver rebuilding a word with a
// valid/ready output and a sticky overrun flag.
module shift_deserializer_16bit
  import shift_deserializer_16bit_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  parameter int CNT_W = 4
) (
  input logic                     clk,
  input logic                     rst,
  shift_deserializer_16bit_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovr_q, ovr_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
  logic [WIDTH-1:0] shifted;

  shift_deserializer_16bit_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .term (cnt_term)
  );

  assign shifted = {shreg_q[WIDTH-2:0], bus.bit_in};

  // FSM: capture, hand off, and police bits arriving in HOLD
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          shreg_d = '0;
          cnt_clr = 1'b1;
          ovr_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bus.start) begin
          shreg_d = '0;
          cnt_clr = 1'b1;
        end else if (bus.bit_valid) begin
          shreg_d = shifted;
          if (cnt_term) begin
            dout_d  = shifted;
            state_d = ST_HOLD;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.bit_valid) begin
          ovr_d = 1'b1;
        end
        if (bus.data_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, shift register, output word and overrun flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out   = dout_q;
  assign bus.data_valid = (state_q == ST_HOLD);
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_shift_deserializer_16bit.sv
// Bench for shift_deserializer_16bit: word-level model
// compared every cycle, plus literal spot checks.
module tb_shift_deserializer_16bit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   cmp_en;

  shift_deserializer_16bit_if #(.WIDTH(16)) bus ();

  shift_deserializer_16bit #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // word-level model: running value and count of bits taken
  bit          m_busy;
  bit          m_valid;
  bit          m_ovr;
  int          m_acc;
  int          m_n;
  logic [15:0] m_out;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy  <= 0;
      m_valid <= 0;
      m_ovr   <= 0;
      m_acc   <= 0;
      m_n     <= 0;
      m_out   <= '0;
    end else if (m_valid) begin
      if (bus.bit_valid) m_ovr <= 1;
      if (bus.data_ready) m_valid <= 0;
    end else if (m_busy) begin
      if (bus.start) begin
        m_acc <= 0;
        m_n   <= 0;
      end else if (bus.bit_valid) begin
        if (m_n + 1 == 16) begin
          m_out   <= 16'((m_acc * 2 + int'(bus.bit_in)) % 65536);
          m_valid <= 1;
          m_busy  <= 0;
          m_acc   <= 0;
          m_n     <= 0;
        end else begin
          m_acc <= m_acc * 2 + int'(bus.bit_in);
          m_n   <= m_n + 1;
        end
      end
    end else if (bus.start) begin
      m_busy <= 1;
      m_acc  <= 0;
      m_n    <= 0;
      m_ovr  <= 0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_data_out", 32'(bus.data_out), 32'(m_out));
      chk("cyc_data_valid", 32'(bus.data_valid), 32'(m_valid));
      chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
      chk("cyc_overrun", 32'(bus.overrun), 32'(m_ovr));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(bit bv, bit b);
    bus.start     = 1;
    bus.bit_valid = bv;
    bus.bit_in    = b;
    tick();
    bus.start     = 0;
    bus.bit_valid = 0;
    bus.bit_in    = 0;
  endtask

  task automatic send_bit(bit b, int gap);
    for (int g = 0; g < gap; g++) tick();
    bus.bit_valid = 1;
    bus.bit_in    = b;
    tick();
    bus.bit_valid = 0;
    bus.bit_in    = 0;
  endtask

  task automatic send_word(logic [15:0] w, int maxgap, bit chk_busy);
    for (int i = 15; i >= 0; i--) begin
      send_bit(w[i], $urandom_range(0, maxgap));
      if (i != 0 && chk_busy) begin
        chk("mid_busy", 32'(bus.busy), 32'd1);
        chk("mid_no_valid", 32'(bus.data_valid), 32'd0);
      end
    end
  endtask

  task automatic consume();
    bus.data_ready = 1;
    tick();
    bus.data_ready = 0;
  endtask

  logic [15:0] ser;

  initial begin
    checks        = 0;
    failures      = 0;
    cmp_en        = 0;
    rst           = 0;
    bus.start     = 0;
    bus.bit_valid = 0;
    bus.bit_in    = 0;
    bus.data_ready = 0;
    tick();
    cmp_en = 1;
    tick();
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_flags", {bus.data_valid, bus.busy, bus.overrun}, 32'h0);
    rst = 1;
    bus.data_ready = 1;
    tick();
    bus.data_ready = 0;
    chk("ready_idle_no_effect", {bus.data_valid, bus.busy}, 32'h0);

    // 1: back-to-back bits of 0xA5C3
    do_start(1, 1);
    chk("t1_busy_after_start", 32'(bus.busy), 32'd1);
    send_word(16'hA5C3, 0, 1);
    chk("t1_valid", 32'(bus.data_valid), 32'd1);
    chk("t1_data", 32'(bus.data_out), 32'h0000A5C3);
    chk("t1_model", 32'(m_out), 32'h0000A5C3);
    chk("t1_busy_low", 32'(bus.busy), 32'd0);
    consume();
    chk("t1_valid_drop", 32'(bus.data_valid), 32'd0);
    chk("t1_data_kept", 32'(bus.data_out), 32'h0000A5C3);

    // 2: 0x8001 with 0-3 cycle gaps
    do_start(0, 0);
    send_word(16'h8001, 3, 1);
    chk("t2_data", 32'(bus.data_out), 32'h00008001);
    chk("t2_model", 32'(m_out), 32'h00008001);
    consume();

    // 3: overrun while word unconsumed
    do_start(0, 0);
    send_word(16'h00FF, 1, 0);
    for (int c = 0; c < 5; c++) begin
      bus.bit_valid = (c == 1 || c == 3);
      bus.bit_in    = 1;
      bus.start     = (c == 2);
      tick();
    end
    bus.bit_valid = 0;
    bus.bit_in    = 0;
    bus.start     = 0;
    chk("t3_overrun", 32'(bus.overrun), 32'd1);
    chk("t3_data", 32'(bus.data_out), 32'h000000FF);
    chk("t3_still_valid", 32'(bus.data_valid), 32'd1);
    consume();
    chk("t3_ovr_sticky", 32'(bus.overrun), 32'd1);

    // 4: start clears overrun; junk then restart
    do_start(0, 0);
    chk("t4_ovr_clear", 32'(bus.overrun), 32'd0);
    for (int j = 0; j < 7; j++) send_bit(j[0], 0);
    do_start(1, 1);
    send_word(16'h1234, 0, 1);
    chk("t4_data", 32'(bus.data_out), 32'h00001234);
    chk("t4_model", 32'(m_out), 32'h00001234);
    consume();

    // 5: asynchronous reset mid-word
    do_start(0, 0);
    for (int j = 0; j < 9; j++) send_bit(1'b1, 0);
    #2 rst = 0;
    #1;
    chk("t5_async_data", 32'(bus.data_out), 32'h0);
    chk("t5_async_flags",
        {bus.data_valid, bus.busy, bus.overrun}, 32'h0);
    tick();
    rst = 1;
    tick();
    do_start(0, 0);
    send_word(16'h0F0F, 2, 1);
    chk("t5_data", 32'(bus.data_out), 32'h00000F0F);
    chk("t5_valid", 32'(bus.data_valid), 32'd1);
    consume();

    // 6: loopback from a left-shift serializer
    ser = 16'hBEEF;
    do_start(0, 0);
    for (int k = 0; k < 16; k++) begin
      bus.bit_valid = 1;
      bus.bit_in    = ser[15];
      tick();
      ser = {ser[14:0], 1'b0};
    end
    bus.bit_valid = 0;
    bus.bit_in    = 0;
    chk("t6_data", 32'(bus.data_out), 32'h0000BEEF);
    chk("t6_valid", 32'(bus.data_valid), 32'd1);
    consume();
    tick();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
